// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh-router definitions (port indices, packet layout,
// XY route helper and the input-port FSM state types).
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;

  localparam int COORD_W     = 2;
  localparam int PAYLOAD_W   = 7;
  localparam int PKT_W       = 2*COORD_W + PAYLOAD_W;
  localparam int DST_X_LSB   = 9;
  localparam int DST_Y_LSB   = 7;
  localparam int PAYLOAD_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  typedef enum logic {IN_IDLE, IN_WAIT_LOW} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_WAIT_ACK, O_WAIT_LOW} out_state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_PORTS-1:0] xy_route(packet_t p,
                                                    logic [COORD_W-1:0] my_x,
                                                    logic [COORD_W-1:0] my_y);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (p.dst_x > my_x)      r[PORT_E]     = 1'b1;
    else if (p.dst_x < my_x) r[PORT_W]     = 1'b1;
    else if (p.dst_y > my_y) r[PORT_N]     = 1'b1;
    else if (p.dst_y < my_y) r[PORT_S]     = 1'b1;
    else                     r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rip_fifo.sv
// rip_fifo: DEPTH-entry synchronous FIFO with occupancy count.
// Head data is read combinationally; push and pop on the same edge are
// both honoured, including push while full when a pop frees the slot.
module rip_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks push-pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_port.sv
// router_input_port: mesh-router input stage. 4-phase req/ack in, FIFO,
// XY route of the head packet, one-hot 4-phase request to the arbiters.
// Define RIP_INPUT_SYNC_EN to pass in_req and out_ack through 2-flop
// synchronizers (asynchronous neighbours); otherwise they are used directly.
module router_input_port
  import noc_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic [NUM_PORTS-1:0]       out_req,
  output logic [WIDTH-1:0]           out_data,
  input  logic [NUM_PORTS-1:0]       out_ack,
  output logic [$clog2(DEPTH):0]     occupancy
);

  logic                 req_s;
  logic [NUM_PORTS-1:0] ack_s;

`ifdef RIP_INPUT_SYNC_EN
  logic [1:0]                  req_sync;
  logic [1:0][NUM_PORTS-1:0]   ack_sync;

  // Two-flop synchronizers for all handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], in_req};
      ack_sync <= {ack_sync[0], out_ack};
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync[1];
`else
  assign req_s = in_req;
  assign ack_s = out_ack;
`endif

  // FIFO
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] fifo_rdata;
  packet_t          head;

  rip_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign head = fifo_rdata;

  // ---------------- input FSM ----------------
  in_state_t in_st, in_nx;

  // Input FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_st <= IN_IDLE;
    else        in_st <= in_nx;
  end

  // Input FSM next state: accept only when a slot is free, then wait for req low.
  always_comb begin
    in_nx = in_st;
    case (in_st)
      IN_IDLE:     if (req_s && !full) in_nx = IN_WAIT_LOW;
      IN_WAIT_LOW: if (!req_s)         in_nx = IN_IDLE;
      default:                         in_nx = IN_IDLE;
    endcase
  end

  // Input FSM outputs: in_ack is the (registered) WAIT_LOW state bit.
  always_comb begin
    push   = (in_st == IN_IDLE) && req_s && !full;
    in_ack = (in_st == IN_WAIT_LOW);
  end

  // ---------------- output FSM ----------------
  out_state_t           o_st, o_nx;
  logic [NUM_PORTS-1:0] dir_q;
  logic                 load, ack_hit;

  assign ack_hit = |(ack_s & dir_q);

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_st <= O_IDLE;
    else        o_st <= o_nx;
  end

  // Output FSM next state: present head, wait ack on chosen port, wait ack low.
  always_comb begin
    o_nx = o_st;
    case (o_st)
      O_IDLE:     if (!empty)  o_nx = O_WAIT_ACK;
      O_WAIT_ACK: if (ack_hit) o_nx = O_WAIT_LOW;
      O_WAIT_LOW: if (!ack_hit) o_nx = O_IDLE;
      default:                 o_nx = O_IDLE;
    endcase
  end

  // Output FSM strobes.
  always_comb begin
    load = (o_st == O_IDLE) && !empty;
    pop  = (o_st == O_WAIT_ACK) && ack_hit;
  end

  // Registered request, direction and data; dir_q outlives out_req so the
  // return-to-zero phase is tracked on the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_req  <= '0;
      dir_q    <= '0;
      out_data <= '0;
    end else if (load) begin
      out_req  <= xy_route(head, COORD_W'(MY_X), COORD_W'(MY_Y));
      dir_q    <= xy_route(head, COORD_W'(MY_X), COORD_W'(MY_Y));
      out_data <= fifo_rdata;
    end else if (pop) begin
      out_req  <= '0;
    end
  end

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port at MY_X=1, MY_Y=1: scoreboard queue of accepted
// packets, per-cycle route/data compare, plus directed literal checks.
module tb_router_input_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_req = 1'b0;
  logic [10:0] in_data = '0;
  logic        in_ack;
  logic [4:0]  out_req;
  logic [10:0] out_data;
  logic [4:0]  out_ack = '0;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [10:0] q[$];
  logic [4:0]  rlog[$];
  bit          arb_en = 1'b0;

`ifdef RIP_INPUT_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  always #5 clk = ~clk;

  router_input_port #(.WIDTH(11), .DEPTH(4), .MY_X(1), .MY_Y(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data),
    .in_ack(in_ack), .out_req(out_req), .out_data(out_data),
    .out_ack(out_ack), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input int x, input int y, input int pl);
    logic [10:0] p;
    p = {x[1:0], y[1:0], pl[6:0]};
    return p;
  endfunction

  // Model of XY routing at (1,1): port index, then one-hot.
  function automatic logic [4:0] route(input logic [10:0] p);
    int dx, dy, idx;
    dx = int'(p[10:9]);
    dy = int'(p[8:7]);
    if (dx > 1)      idx = 2;
    else if (dx < 1) idx = 4;
    else if (dy > 1) idx = 1;
    else if (dy < 1) idx = 3;
    else             idx = 0;
    return 5'(1 << idx);
  endfunction

  // Compare: whenever a request is up it must be the model head's route and data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("occ_bound", {31'd0, occupancy <= 3'd4}, 32'd1);
      if (out_req != 0) begin
        chk("route", out_req, q.size() > 0 ? route(q[0]) : 5'd0);
        chk("data", out_data, q.size() > 0 ? q[0] : 11'h7ff);
      end
    end
  end

  // Arbiter model: ack the requested port, drop once request clears, log it.
  always @(negedge clk) begin
    if (!rst_n) out_ack = '0;
    else if (arb_en) begin
      if (out_ack != 0) begin
        if (out_req == 0) begin
          rlog.push_back(out_ack);
          if (q.size() > 0) void'(q.pop_front());
          out_ack = '0;
        end
      end else if (out_req != 0) begin
        out_ack = out_req;
      end
    end
  end

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (in_ack !== lvl && n < 100) begin @(negedge clk); n++; end
    chk(name, in_ack, lvl);
  endtask

  task automatic send(input logic [10:0] p);
    @(negedge clk);
    in_data = p;
    in_req  = 1'b1;
    wait_ack(1'b1, "send_ack_hi");
    q.push_back(p);
    in_req = 1'b0;
    wait_ack(1'b0, "send_ack_lo");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(occupancy == 0 && out_req == 0 && out_ack == 0 && in_ack == 0) && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_occ", occupancy, 0);
    chk("drain_q", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] p5, pa, pb, pc;
    int n;

    // Reset values
    #1;
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single eastbound packet
    send(mk(3, 1, 7'h15));
    repeat (3) @(negedge clk);
    chk("t1_occ", occupancy, 1);
    chk("t1_req_E", out_req, 5'b00100);
    chk("t1_data", out_data, 11'h695);
    arb_en = 1'b1;
    wait_idle();
    chk("t1_log", rlog.size() > 0 ? rlog[0] : 5'd0, 5'b00100);
    rlog.delete();

    // Local, S, W, N
    send(mk(1, 1, 1)); send(mk(1, 0, 2)); send(mk(0, 2, 3)); send(mk(1, 3, 4));
    wait_idle();
    chk("t2_n", rlog.size(), 4);
    if (rlog.size() == 4) begin
      chk("t2_local", rlog[0], 5'b00001);
      chk("t2_S",     rlog[1], 5'b01000);
      chk("t2_W",     rlog[2], 5'b10000);
      chk("t2_N",     rlog[3], 5'b00010);
    end
    rlog.delete();

    // Fill, back-pressure the fifth, release one slot
    arb_en = 1'b0;
    send(mk(2, 0, 10)); send(mk(0, 0, 11)); send(mk(1, 2, 12)); send(mk(1, 1, 13));
    repeat (2) @(negedge clk);
    chk("t3_full", occupancy, 4);
    p5 = mk(3, 3, 14);
    @(negedge clk); in_data = p5; in_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_held_ack", in_ack, 0);
      chk("t3_held_occ", occupancy, 4);
    end
    arb_en = 1'b1;
    n = 0;
    while (occupancy != 3 && n < 100) begin @(negedge clk); n++; end
    chk("t3_popped", occupancy, 3);
    @(posedge clk); #1;
    chk("t3_accept_ack", in_ack, 1);
    chk("t3_accept_occ", occupancy, 4);
    q.push_back(p5);
    @(negedge clk) in_req = 1'b0;
    wait_ack(1'b0, "t3_ack_lo");
    wait_idle();
    chk("t3_n", rlog.size(), 5);
    rlog.delete();

    // Simultaneous push and pop at occupancy 2
    arb_en = 1'b0;
    pa = mk(2, 2, 20); pb = mk(0, 3, 21); pc = mk(1, 0, 22);
    send(pa); send(pb);
    repeat (3) @(negedge clk);
    chk("t4_occ2", occupancy, 2);
    chk("t4_req", out_req, 5'b00100);
    @(negedge clk);
    in_data = pc; in_req = 1'b1; out_ack = out_req;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (in_ack !== 1'b1 && n < 20);
    chk("t4_ack", in_ack, 1);
    chk("t4_occ_same", occupancy, 2);
    chk("t4_req_clr", out_req, 0);
    void'(q.pop_front());
    q.push_back(pc);
    @(negedge clk);
    in_req = 1'b0; out_ack = '0; arb_en = 1'b1;
    wait_ack(1'b0, "t4_ack_lo");
    wait_idle();
    rlog.delete();

    // Ten back-to-back through pointer wrap
    for (int i = 0; i < 10; i++) send(mk(i % 4, (i * 3) % 4, i + 40));
    wait_idle();
    chk("t4_n10", rlog.size(), 10);
    rlog.delete();

    // Asynchronous reset mid-handshake
    arb_en = 1'b0;
    send(mk(3, 3, 50));
    repeat (3) @(negedge clk);
    @(negedge clk); in_data = mk(0, 0, 51); in_req = 1'b1;
    wait_ack(1'b1, "t5_ack_hi");
    chk("t5_req_hi", out_req, 5'b00100);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", in_ack, 0);
    chk("t5_rst_req", out_req, 0);
    chk("t5_rst_occ", occupancy, 0);
    q.delete(); rlog.delete();
    in_req = 1'b0; out_ack = '0;
    @(negedge clk) rst_n = 1'b1;
    arb_en = 1'b1;
    send(mk(0, 1, 52));
    wait_idle();
    chk("t5_route_W", rlog.size() > 0 ? rlog[0] : 5'd0, 5'b10000);
    rlog.delete();

    // Input acknowledge latency
    @(negedge clk); in_data = mk(1, 1, 60); in_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (in_ack !== 1'b1 && n < 20);
    chk("t6_ack_latency", n, ACK_LAT);
    q.push_back(mk(1, 1, 60));
    @(negedge clk) in_req = 1'b0;
    wait_ack(1'b0, "t6_ack_lo");
    wait_idle();
    chk("t6_local", rlog.size() > 0 ? rlog[0] : 5'd0, 5'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
